// File: rtl/fpu_round.sv
// Rounding/packing stage behind the FP add/sub normaliser.
// Takes {sign, exp, frac, G, R, S}, applies the RISC-V rounding mode and
// produces an IEEE-754 single result, per-op fflags and sticky accrued flags.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid never depends on ready, and the producer holds data stable
// while valid is high and ready is low. Both stages advance together on
// en = ~out_valid | out_ready, so in_ready = en and bubbles are not collapsed.
module fpu_round #(
  parameter int                         EXP_W     = 8,
  parameter int                         FRAC_W    = 23,
  parameter logic [EXP_W+FRAC_W:0]      CANON_NAN = 32'h7FC00000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [EXP_W+FRAC_W+3:0]       in_data,
  input  logic [2:0]                    in_rm,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [EXP_W+FRAC_W:0]         out_data,
  output logic [4:0]                    out_flags,
  input  logic                          flags_clr,
  output logic [4:0]                    flags_acc
);

  localparam int MW = EXP_W + FRAC_W;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [EXP_W-1:0]  EXP_ONES  = '1;
  localparam logic [FRAC_W-1:0] FRAC_ONES = '1;

  // Input field split
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [FRAC_W-1:0] in_frac;
  logic              in_g, in_r, in_s;
  logic              in_inx;
  logic              in_inc;

  assign in_sign = in_data[MW+3];
  assign in_exp  = in_data[MW+2 -: EXP_W];
  assign in_frac = in_data[FRAC_W+2:3];
  assign in_g    = in_data[2];
  assign in_r    = in_data[1];
  assign in_s    = in_data[0];
  assign in_inx  = in_g | in_r | in_s;

  // Stage 1 state
  logic              s1_valid;
  logic              s1_sign;
  logic [EXP_W-1:0]  s1_exp;
  logic [FRAC_W-1:0] s1_frac;
  logic [2:0]        s1_rm;
  logic              s1_inx;
  logic              s1_inc;

  logic en;
  logic hs;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign hs       = out_valid & out_ready;

  // Increment decision per rounding mode; reserved encodings behave as RNE
  always_comb begin
    in_inc = in_g & (in_r | in_s | in_frac[0]);
    case (in_rm)
      RM_RTZ:  in_inc = 1'b0;
      RM_RDN:  in_inc = in_sign & in_inx;
      RM_RUP:  in_inc = ~in_sign & in_inx;
      RM_RMM:  in_inc = in_g;
      default: in_inc = in_g & (in_r | in_s | in_frac[0]);
    endcase
  end

  // Stage 2 combinational result
  logic [MW-1:0] sum;
  logic [MW:0]   nxt_data;
  logic [4:0]    nxt_flags;
  logic          to_max;

  assign sum    = {s1_exp, s1_frac} + {{(MW-1){1'b0}}, s1_inc};
  assign to_max = (s1_rm == RM_RTZ) || ((s1_rm == RM_RDN) && !s1_sign) ||
                  ((s1_rm == RM_RUP) && s1_sign);

  // Pack result: specials first, then overflow, then the normal rounded value
  always_comb begin
    nxt_data  = {s1_sign, sum};
    nxt_flags = {3'b000, s1_inx & (s1_exp == '0), s1_inx};
    if (s1_exp == EXP_ONES) begin
      if (s1_frac != '0) begin
        nxt_data  = CANON_NAN;
        nxt_flags = {~s1_frac[FRAC_W-1], 4'b0000};
      end else begin
        nxt_data  = {s1_sign, EXP_ONES, {FRAC_W{1'b0}}};
        nxt_flags = 5'b00000;
      end
    end else if (sum[MW-1:FRAC_W] == EXP_ONES) begin
      nxt_flags = 5'b00101;
      if (to_max) nxt_data = {s1_sign, EXP_ONES - 1'b1, FRAC_ONES};
      else        nxt_data = {s1_sign, EXP_ONES, {FRAC_W{1'b0}}};
    end
  end

  // Pipeline registers; flush clears valids but leaves data untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_frac   <= '0;
      s1_rm     <= 3'b000;
      s1_inx    <= 1'b0;
      s1_inc    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= 5'b00000;
    end else begin
      if (flush) begin
        s1_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else if (en) begin
        s1_valid  <= in_valid;
        out_valid <= s1_valid;
      end
      if (!flush && en && in_valid) begin
        s1_sign <= in_sign;
        s1_exp  <= in_exp;
        s1_frac <= in_frac;
        s1_rm   <= in_rm;
        s1_inx  <= in_inx;
        s1_inc  <= in_inc;
      end
      if (!flush && en && s1_valid) begin
        out_data  <= nxt_data;
        out_flags <= nxt_flags;
      end
    end
  end

  // Sticky accrued flags; clear wins but still keeps a same-cycle handshake
  always_ff @(posedge clk) begin
    if (rst)            flags_acc <= 5'b00000;
    else if (flags_clr) flags_acc <= hs ? out_flags : 5'b00000;
    else if (hs)        flags_acc <= flags_acc | out_flags;
  end

endmodule

// File: tb/tb_fpu_round.sv
// Bench for fpu_round: directed vector table, backpressure/flush/reset
// sequences and a randomized stream checked against a reference model.
module tb_fpu_round;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [34:0] in_data;
  logic [2:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_flags;
  logic        flags_clr;
  logic [4:0]  flags_acc;

  fpu_round dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .flags_clr(flags_clr), .flags_acc(flags_acc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          hs_count = 0;
  logic [36:0] exp_q[$];
  logic [36:0] drv_exp;
  logic [4:0]  acc_model;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on the magnitude {exp,frac} as an integer and the GRS bits as a
  // fraction of one ulp in eighths (4 = exactly half).
  function automatic logic [36:0] ref_round(input logic [34:0] d, input logic [2:0] rm);
    logic        sign;
    int unsigned e, f, rem, mag, mode;
    bit          up, nx, to_inf;
    sign = d[34];
    e    = int'(d[33:26]);
    f    = int'(d[25:3]);
    rem  = int'(d[2:0]);
    if (e == 255) begin
      if (f != 0) return {32'h7FC00000, (f < 32'h400000) ? 5'b10000 : 5'b00000};
      return {sign, 8'hFF, 23'h0, 5'b00000};
    end
    mode = (rm > 3'd4) ? 0 : int'(rm);
    case (mode)
      0:       up = (rem > 4) || (rem == 4 && (f % 2) == 1);
      1:       up = 1'b0;
      2:       up = sign && rem != 0;
      3:       up = !sign && rem != 0;
      default: up = rem >= 4;
    endcase
    nx  = rem != 0;
    mag = e * 32'h800000 + f + (up ? 1 : 0);
    if (mag / 32'h800000 == 255) begin
      to_inf = (mode == 0) || (mode == 4) || (mode == 2 && sign) || (mode == 3 && !sign);
      if (to_inf) return {sign, 8'hFF, 23'h0, 5'b00101};
      return {sign, 8'hFE, 23'h7FFFFF, 5'b00101};
    end
    return {sign, mag[30:0], 3'b000, (nx && e == 0), nx};
  endfunction

  // ---------------- driver tasks ----------------
  // Holds the op until the DUT takes it (bounded).
  task automatic send(input logic [34:0] d, input logic [2:0] rm, input logic [36:0] ex);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    in_rm    = rm;
    drv_exp  = ex;
    n = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL send_timeout in_ready never rose");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [34:0] d, input logic [2:0] rm);
    send(d, rm, ref_round(d, rm));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [36:0] e;
    logic [4:0]  hs_f;
    if (rst) begin
      exp_q.delete();
      acc_model = 5'b00000;
    end else begin
      hs_f = 5'b00000;
      total++;
      if (flags_acc !== acc_model) begin
        bad++;
        $display("FAIL flags_acc got=%b want=%b", flags_acc, acc_model);
      end
      if (out_valid && out_ready) begin
        hs_count++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output got=%h flags=%b want=none", out_data, out_flags);
        end else begin
          e = exp_q.pop_front();
          hs_f = e[4:0];
          if ({out_data, out_flags} !== e) begin
            bad++;
            $display("FAIL result got=%h/%b want=%h/%b", out_data, out_flags, e[36:5], e[4:0]);
          end
        end
      end
      acc_model = flags_clr ? hs_f : (acc_model | hs_f);
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(drv_exp);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [34:0] d;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  vec_t vt[14];

  function automatic logic [34:0] pk(input logic s, input logic [7:0] e,
                                     input logic [22:0] f, input logic [2:0] grs);
    return {s, e, f, grs};
  endfunction

  logic        stop_rand;
  logic [34:0] rd;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_rm = 3'b000;
    out_ready = 1'b1; flags_clr = 1'b0; drv_exp = '0; acc_model = 5'b00000;
    stop_rand = 1'b0;

    vt[0]  = '{pk(0, 8'h7F, 23'h000000, 3'b100), 3'd0, 32'h3F800000, 5'b00001};
    vt[1]  = '{pk(0, 8'h7F, 23'h000001, 3'b100), 3'd0, 32'h3F800002, 5'b00001};
    vt[2]  = '{pk(0, 8'h7F, 23'h7FFFFF, 3'b110), 3'd0, 32'h40000000, 5'b00001};
    vt[3]  = '{pk(0, 8'h7F, 23'h7FFFFF, 3'b110), 3'd1, 32'h3FFFFFFF, 5'b00001};
    vt[4]  = '{pk(0, 8'hFE, 23'h7FFFFF, 3'b100), 3'd0, 32'h7F800000, 5'b00101};
    vt[5]  = '{pk(0, 8'hFE, 23'h7FFFFF, 3'b100), 3'd1, 32'h7F7FFFFF, 5'b00001};
    vt[6]  = '{pk(1, 8'hFE, 23'h7FFFFF, 3'b100), 3'd3, 32'hFF7FFFFF, 5'b00001};
    vt[7]  = '{pk(0, 8'hFF, 23'h000001, 3'b000), 3'd0, 32'h7FC00000, 5'b10000};
    vt[8]  = '{pk(0, 8'hFF, 23'h400000, 3'b000), 3'd0, 32'h7FC00000, 5'b00000};
    vt[9]  = '{pk(1, 8'hFF, 23'h000000, 3'b000), 3'd0, 32'hFF800000, 5'b00000};
    vt[10] = '{pk(0, 8'h00, 23'h7FFFFF, 3'b100), 3'd0, 32'h00800000, 5'b00011};
    vt[11] = '{pk(1, 8'h00, 23'h000000, 3'b000), 3'd2, 32'h80000000, 5'b00000};
    vt[12] = '{pk(0, 8'h7F, 23'h000001, 3'b100), 3'd5, 32'h3F800002, 5'b00001};
    vt[13] = '{pk(0, 8'hFE, 23'h7FFFFF, 3'b001), 3'd3, 32'h7F800000, 5'b00101};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    chk("rst_flags_acc", 64'(flags_acc), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed vectors, streamed back to back
    for (int i = 0; i < 14; i++) send(vt[i].d, vt[i].rm, {vt[i].res, vt[i].flg});
    drain();

    // Accrued flags: NX op then OF op
    flags_clr = 1'b1; @(posedge clk); #1 flags_clr = 1'b0;
    send(vt[0].d, vt[0].rm, {vt[0].res, vt[0].flg});
    send(vt[4].d, vt[4].rm, {vt[4].res, vt[4].flg});
    drain();
    @(negedge clk);
    chk("acc_nx_of", 64'(flags_acc), 64'b00101);

    // flags_clr in the same cycle as an NV handshake
    @(posedge clk); #1 out_ready = 1'b0;
    send(vt[7].d, vt[7].rm, {vt[7].res, vt[7].flg});
    for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
    @(posedge clk); #1 flags_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 flags_clr = 1'b0;
    @(negedge clk);
    chk("acc_clr_nv", 64'(flags_acc), 64'b10000);

    // Backpressure: 3 back-to-back ops, consumer stalled for 5 cycles
    @(posedge clk); #1 out_ready = 1'b0;
    begin
      int hs0;
      hs0 = hs_count;
      fork
        begin
          send(vt[1].d, vt[1].rm, {vt[1].res, vt[1].flg});
          send(vt[2].d, vt[2].rm, {vt[2].res, vt[2].flg});
          send(vt[9].d, vt[9].rm, {vt[9].res, vt[9].flg});
        end
        begin
          repeat (2) @(posedge clk);
          for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_data", 64'({out_valid, out_data}), {31'd0, 1'b1, vt[1].res});
          end
          @(posedge clk); #1 out_ready = 1'b1;
        end
      join
      drain();
      chk("bp_delivered", 64'(hs_count - hs0), 64'd3);
    end

    // Flush with two ops in flight: neither may be delivered
    @(posedge clk); #1 out_ready = 1'b0;
    send(vt[2].d, vt[2].rm, {vt[2].res, vt[2].flg});
    send(vt[3].d, vt[3].rm, {vt[3].res, vt[3].flg});
    flush = 1'b1; @(posedge clk); #1 flush = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("flush_no_out", 64'(out_valid), 64'd0);
    end

    // Reset mid-operation drops in-flight ops and clears accrued flags
    @(posedge clk); #1;
    send(vt[7].d, vt[7].rm, {vt[7].res, vt[7].flg});
    send(vt[4].d, vt[4].rm, {vt[4].res, vt[4].flg});
    do_reset();
    @(negedge clk);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_acc", 64'(flags_acc), 64'd0);
    @(posedge clk); #1;

    // Randomized stream with random backpressure, clears and rare flushes
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          int ep;
          ep = $urandom_range(0, 5);
          rd[34] = 1'($urandom_range(0, 1));
          case (ep)
            0:       rd[33:26] = 8'h00;
            1:       rd[33:26] = 8'hFE;
            2:       rd[33:26] = 8'hFF;
            3:       rd[33:26] = 8'h7F;
            default: rd[33:26] = 8'($urandom_range(0, 255));
          endcase
          case ($urandom_range(0, 3))
            0:       rd[25:3] = 23'h7FFFFF;
            1:       rd[25:3] = 23'h0;
            default: rd[25:3] = 23'($urandom);
          endcase
          rd[2:0] = 3'($urandom_range(0, 7));
          if ($urandom_range(0, 49) == 0) begin
            flush = 1'b1; @(posedge clk); #1 flush = 1'b0;
          end
          send_m(rd, 3'($urandom_range(0, 7)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 9) < 7);
          flags_clr = ($urandom_range(0, 29) == 0);
        end
        out_ready = 1'b1;
        flags_clr = 1'b0;
      end
    join
    drain();
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
